// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction decode stage. Opcodes with an all-zero prefix
//                decode to a one-hot vector; any other instruction is flagged
//                illegal and decodes to NOP. Results are buffered in a
//                2-entry in-order FIFO with valid/ready handshakes on both
//                sides. A saturating, clearable counter tracks how many
//                illegal instructions were accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
   parameter int INW  = 8,
   parameter int OPW  = 4,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INW-1:0]      instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2**OPW-1:0]   decoded,
   output logic                out_illegal,
   output logic [CNTW-1:0]     illegal_count,
   input  logic                clear_count
);

   localparam int            DW        = 2**OPW;
   localparam logic [DW-1:0] c_nop     = DW'(1);
   localparam logic [CNTW-1:0] c_cnt_max = '1;

   // Two-entry storage; r_head selects the oldest entry, r_count is occupancy
   logic [DW-1:0]   r_dec [2];
   logic [1:0]      r_ill;
   logic            r_head;
   logic [1:0]      r_count;
   // Held low through reset so in_ready only rises on the first clock edge
   // after release, and stays a pure function of registered state
   logic            r_live;
   logic [CNTW-1:0] r_illegal_count;

   logic            w_prefix_zero;
   logic [DW-1:0]   w_entry_dec;
   logic            w_accept;
   logic            w_pop;
   logic            w_wr_ptr;

   // Decode of the incoming instruction and handshake qualifiers
   always_comb begin
      w_prefix_zero = (instr[INW-1:OPW] == '0);
      w_entry_dec   = w_prefix_zero ? (c_nop << instr[OPW-1:0]) : c_nop;
      w_accept      = in_valid & in_ready;
      w_pop         = out_valid & out_ready;
      // Next free slot sits right after the occupied ones (modulo 2)
      w_wr_ptr      = r_head ^ r_count[0];
   end

   // Output view of the FIFO head; NOP/legal when empty
   always_comb begin
      in_ready      = r_live & (r_count != 2'd2);
      out_valid     = (r_count != 2'd0);
      decoded       = out_valid ? r_dec[r_head] : c_nop;
      out_illegal   = out_valid & r_ill[r_head];
      illegal_count = r_illegal_count;
   end

   // FIFO storage, head pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dec[0] <= c_nop;
         r_dec[1] <= c_nop;
         r_ill    <= 2'b00;
         r_head   <= 1'b0;
         r_count  <= 2'd0;
         r_live   <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_dec[w_wr_ptr] <= w_entry_dec;
            r_ill[w_wr_ptr] <= ~w_prefix_zero;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating illegal-instruction counter; clear wins over increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_illegal_count <= '0;
      end else if (clear_count) begin
         r_illegal_count <= '0;
      end else if (w_accept && !w_prefix_zero && (r_illegal_count != c_cnt_max)) begin
         r_illegal_count <= r_illegal_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  instr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] decoded;
   logic        out_illegal;
   logic [1:0]  illegal_count;
   logic        clear_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   decode_stage #(.INW(8), .OPW(4), .CNTW(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .instr         (instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .decoded       (decoded),
      .out_illegal   (out_illegal),
      .illegal_count (illegal_count),
      .clear_count   (clear_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] dec;
      bit          ill;
   } ent_t;

   ent_t q[$];
   int   m_cnt  = 0;
   bit   m_live = 0;

   function automatic logic [15:0] spec_dec(input logic [7:0] ins);
      logic [15:0] one;
      one = 16'h0001;
      if (ins[7:4] == 4'h0) return one << ins[3:0];
      return 16'h0001;
   endfunction

   always @(negedge reset_n) begin
      q.delete();
      m_cnt  = 0;
      m_live = 0;
   end

   always @(posedge clk) begin
      if (reset_n) begin
         bit   acc, pop;
         ent_t e;
         acc = in_valid && m_live && (q.size() < 2);
         pop = (q.size() > 0) && out_ready;
         if (pop) void'(q.pop_front());
         if (acc) begin
            e.dec = spec_dec(instr);
            e.ill = (instr[7:4] != 4'h0);
            q.push_back(e);
         end
         if (clear_count) m_cnt = 0;
         else if (acc && instr[7:4] != 4'h0 && m_cnt < 3) m_cnt++;
         m_live = 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         chk("m_in_ready",  32'(in_ready),      32'(m_live && q.size() < 2));
         chk("m_out_valid", 32'(out_valid),     32'(q.size() > 0));
         chk("m_decoded",   32'(decoded),       (q.size() > 0) ? 32'(q[0].dec) : 32'h1);
         chk("m_illegal",   32'(out_illegal),   (q.size() > 0) ? 32'(q[0].ill) : 32'h0);
         chk("m_count",     32'(illegal_count), 32'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] e;
      reset_n = 1'b0; in_valid = 1'b0; instr = 8'h00;
      out_ready = 1'b0; clear_count = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_decoded",   32'(decoded), 32'h1);
      chk("rst_illegal",   32'(out_illegal), 32'h0);
      chk("rst_count",     32'(illegal_count), 32'h0);
      @(negedge clk); #1 reset_n = 1'b1;
      chk_en = 1;
      @(posedge clk); #1;
      chk("first_edge_in_ready", 32'(in_ready), 32'h1);

      // Single legal
      @(negedge clk); in_valid = 1'b1; instr = 8'h05; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0; #1;
      chk("legal_valid",   32'(out_valid), 32'h1);
      chk("legal_decoded", 32'(decoded), 32'h0020);
      chk("legal_illegal", 32'(out_illegal), 32'h0);
      @(negedge clk); #1;
      chk("legal_drained", 32'(out_valid), 32'h0);

      // Illegal
      in_valid = 1'b1; instr = 8'h35;
      @(negedge clk); in_valid = 1'b0; #1;
      chk("ill_decoded", 32'(decoded), 32'h0001);
      chk("ill_flag",    32'(out_illegal), 32'h1);
      chk("ill_count",   32'(illegal_count), 32'h1);

      // Backpressure
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; instr = 8'h01;
      @(negedge clk); instr = 8'h0F;
      @(negedge clk); in_valid = 1'b0; #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_head",     32'(decoded), 32'h0002);
      @(negedge clk); #1;
      chk("bp_hold", 32'(decoded), 32'h0002);
      out_ready = 1'b1;
      @(negedge clk); #1;
      chk("bp_second",  32'(decoded), 32'h8000);
      chk("bp_ready_back", 32'(in_ready), 32'h1);
      @(negedge clk);

      // Streaming opcodes 0..9
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            #1;
            e = 16'h0001;
            e = e << (i - 1);
            chk("stream_dec", 32'(decoded), 32'(e));
            chk("stream_rdy", 32'(in_ready), 32'h1);
         end
         in_valid = 1'b1; instr = 8'(i);
      end
      @(negedge clk); in_valid = 1'b0; #1;
      chk("stream_last", 32'(decoded), 32'h0200);
      @(negedge clk);

      // Saturation and clear priority
      clear_count = 1'b1;
      @(negedge clk); clear_count = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; instr = 8'(8'h40 + i);
         @(negedge clk);
      end
      in_valid = 1'b0; #1;
      chk("sat_count", 32'(illegal_count), 32'h3);
      in_valid = 1'b1; instr = 8'h80; clear_count = 1'b1;
      @(negedge clk); in_valid = 1'b0; clear_count = 1'b0; #1;
      chk("clear_prio", 32'(illegal_count), 32'h0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         clear_count = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) < 7) instr = {4'h0, 4'($urandom)};
         else                          instr = {4'($urandom_range(1, 15)), 4'($urandom)};
      end

      // Reset mid-stream with a full FIFO
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
      @(negedge clk);
      @(negedge clk); clear_count = 1'b1;
      @(negedge clk); clear_count = 1'b0; out_ready = 1'b0; in_valid = 1'b1; instr = 8'h35;
      @(negedge clk); instr = 8'hF2;
      @(negedge clk); in_valid = 1'b0; #1;
      chk("full_in_ready", 32'(in_ready), 32'h0);
      chk("full_count",    32'(illegal_count), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid",  32'(out_valid), 32'h0);
      chk("async_count",  32'(illegal_count), 32'h0);
      chk("async_ready",  32'(in_ready), 32'h0);
      chk("async_dec",    32'(decoded), 32'h1);
      @(negedge clk);
      @(negedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("no_stale", 32'(out_valid), 32'h0);
      end

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter INW, default 8: instruction width in bits.
REQ-002 SHALL have parameter OPW, default 4: opcode field width; instr[OPW-1:0]; legal range 1..INW-1.
REQ-003 SHALL have parameter CNTW, default 8: illegal-instruction counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: instr holds a valid instruction.
REQ-007 SHALL have port in_ready, output, 1: block can accept an instruction this cycle.
REQ-008 SHALL have port instr, input, INW: raw instruction.
REQ-009 SHALL have port out_valid, output, 1: decoded/out_illegal hold a valid entry.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the entry this cycle.
REQ-011 SHALL have port decoded, output, 2**OPW: one-hot decoded opcode; bit 0 = NOP, MSB = highest opcode.
REQ-012 SHALL have port out_illegal, output, 1: the current entry came from an illegal instruction.
REQ-013 SHALL have port illegal_count, output, CNTW: saturating count of accepted illegal instructions.
REQ-014 SHALL have port clear_count, input, 1: synchronous clear of illegal_count.

Function
REQ-015 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL treat prefix = instr[INW-1:OPW] == 0 as legal: entry decoded = 1 << instr[OPW-1:0], illegal = 0.
REQ-017 SHALL treat a nonzero prefix as illegal: entry decoded = NOP pattern (bit 0 only), illegal = 1.
REQ-018 SHALL capture decode results at accept into a 2-entry in-order FIFO; occupancy is 0, 1 or 2.
REQ-019 SHALL present an accepted entry at the outputs no earlier than the next cycle (1-cycle latency when empty); instr is never combinationally passed to decoded.
REQ-020 SHALL drive in_ready = (occupancy < 2), from registered state only; it SHALL NOT depend on out_ready or in_valid.
REQ-021 SHALL drive out_valid = (occupancy > 0), with decoded/out_illegal taken from the head entry.
REQ-022 SHALL keep decoded and out_illegal stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when out_valid=0, drive decoded = NOP pattern and out_illegal = 0.
REQ-024 SHALL apply occupancy updates: accept only -> +1; pop only -> -1; both -> unchanged, head advances and new entry appended.
REQ-025 SHALL, at occupancy 2, ignore in_valid (in_ready=0); a pop in that cycle leaves occupancy 1 and in_ready=1 the following cycle.
REQ-026 SHALL ignore out_ready while empty; occupancy never underflows.
REQ-027 SHALL increment illegal_count by 1 on each accept of an illegal instruction, saturating at 2**CNTW-1 with no wrap.
REQ-028 SHALL give clear_count priority: on a cycle with clear_count=1, illegal_count becomes 0 regardless of a simultaneous illegal accept.
REQ-029 SHALL NOT increment illegal_count for instructions that are presented but not accepted.

Reset
REQ-030 SHALL, while reset_n=0, immediately force: occupancy 0, out_valid 0, in_ready 0, decoded = NOP pattern, out_illegal 0, illegal_count 0.
REQ-031 SHALL assert in_ready=1 on the first rising clk edge after reset_n is released.
REQ-032 SHALL discard FIFO contents when reset is asserted mid-operation; no stale entry appears after release.

Verification
REQ-033 Single legal: instr=8'h05 accepted, out_ready=1 -> next cycle out_valid=1, decoded=16'h0020, out_illegal=0; following cycle out_valid=0.
REQ-034 Illegal: instr=8'h35 accepted -> decoded=16'h0001, out_illegal=1, illegal_count 0->1.
REQ-035 Backpressure: out_ready=0; accept 8'h01 then 8'h0F -> in_ready=0 at occupancy 2, decoded=16'h0002 held; raise out_ready -> 16'h0002 then 16'h8000, in order.
REQ-036 Streaming: in_valid=1 and out_ready=1 for 10 cycles with opcodes 0..9 -> one output per cycle after 1-cycle latency, occupancy stays 1, no drops.
REQ-037 Saturation/clear: CNTW=2, accept 5 illegal instructions -> illegal_count=3; clear_count pulsed together with an illegal accept -> 0.
REQ-038 Reset mid-stream: occupancy 2, assert reset_n=0 asynchronously -> out_valid=0 and illegal_count=0 immediately; after release no prior entry is emitted.
